fifo_flagged: RTL and testbench

Parametrised single-clock FIFO, successor to the basic `fifo`. It adds:
- selectable first-word-fall-through (FWFT) or registered-read mode;
- an occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags and a synchronous flush.

It sits between producer and consumer datapaths in the same clock domain, as a drop-in upgrade where flow control needs early warning.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_flagged_if.sv | 35 +++
 rtl/fifo_ram.sv | 23 ++
 rtl/fifo_flagged.sv | 106 ++++++++++
 tb/tb_fifo_flagged.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo family: width derivation and read-mode constants.
package fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Count must represent 0..depth inclusive, hence depth+1 values.
   function automatic int count_w(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int addr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Producer/consumer side of fifo_flagged: write/read requests, data and status.
interface fifo_flagged_if #(
   parameter int width = 8,
   parameter int depth = 8
);
   import fifo_pkg::*;

   localparam int cnt_w = count_w(depth);

   logic             clear_i;
   logic             wr_en_i;
   logic             rd_en_i;
   logic [width-1:0] din_i;
   logic [width-1:0] dout_o;
   logic             full_o;
   logic             empty_o;
   logic             almost_full_o;
   logic             almost_empty_o;
   logic [cnt_w-1:0] count_o;
   logic             overflow_o;
   logic             underflow_o;

   modport master (
      output clear_i, wr_en_i, rd_en_i, din_i,
      input  dout_o, full_o, empty_o, almost_full_o, almost_empty_o,
             count_o, overflow_o, underflow_o
   );

   modport slave (
      input  clear_i, wr_en_i, rd_en_i, din_i,
      output dout_o, full_o, empty_o, almost_full_o, almost_empty_o,
             count_o, overflow_o, underflow_o
   );

endinterface

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
   parameter int depth = 8,
   parameter int width = 8,
   parameter int aw    = 3
) (
   input  logic             clk_i,
   input  logic             wr_en,
   input  logic [aw-1:0]    wr_addr,
   input  logic [width-1:0] wr_data,
   input  logic [aw-1:0]    rd_addr,
   output logic [width-1:0] rd_data
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT output.
module fifo_flagged
   import fifo_pkg::*;
#(
   parameter int depth         = 8,
   parameter int width         = 8,
   parameter int afull_thresh  = depth - 2,
   parameter int aempty_thresh = 2,
   parameter int fwft          = FIFO_MODE_REG
) (
   input  logic          clk_i,
   input  logic          reset_i,
   fifo_flagged_if.slave bus
);

   localparam int aw = addr_w(depth);
   localparam int cw = count_w(depth);

   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [cw-1:0]    count;
   logic             ovf;
   logic             unf;
   logic             full;
   logic             empty;
   logic             rd_accept;
   logic             wr_accept;
   logic [width-1:0] rd_data;

   function automatic logic [aw-1:0] next_ptr(input logic [aw-1:0] p);
      return (p == aw'(depth - 1)) ? '0 : p + aw'(1);
   endfunction

   assign full  = (count == cw'(depth));
   assign empty = (count == '0);

   // A full FIFO still takes a write when a read frees a slot in the same cycle;
   // an empty FIFO never serves a read, even alongside a write.
   always_comb begin
      rd_accept = bus.rd_en_i && !empty && !bus.clear_i;
      wr_accept = bus.wr_en_i && (!full || rd_accept) && !bus.clear_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else if (bus.clear_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
         if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + cw'(1);
            2'b01:   count <= count - cw'(1);
            default: count <= count;
         endcase
         ovf <= ovf | (bus.wr_en_i && !wr_accept);
         unf <= unf | (bus.rd_en_i && !rd_accept);
      end
   end

   fifo_ram #(
      .depth (depth),
      .width (width),
      .aw    (aw)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr),
      .wr_data (bus.din_i),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   generate
      if (fwft == FIFO_MODE_FWFT) begin : g_fwft
         // Head word shows through directly; forced to zero while empty.
         assign bus.dout_o = empty ? '0 : rd_data;
      end else begin : g_reg
         logic [width-1:0] dout_q;
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)        dout_q <= '0;
            else if (rd_accept) dout_q <= rd_data;
         end
         assign bus.dout_o = dout_q;
      end
   endgenerate

   assign bus.full_o         = full;
   assign bus.empty_o        = empty;
   assign bus.almost_full_o  = (count >= cw'(afull_thresh));
   assign bus.almost_empty_o = (count <= cw'(aempty_thresh));
   assign bus.count_o        = count;
   assign bus.overflow_o     = ovf;
   assign bus.underflow_o    = unf;

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: three instances (depth 8 registered, depth 8 FWFT,
// depth 5 FWFT) share one stimulus stream and are checked against queue models.
module tb_fifo_flagged;
   import fifo_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr  = 1'b0;
   logic       rd  = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] din = 8'h00;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_flagged_if #(.width(8), .depth(8)) b0 ();
   fifo_flagged_if #(.width(8), .depth(8)) b1 ();
   fifo_flagged_if #(.width(8), .depth(5)) b2 ();

   assign b0.wr_en_i = wr;  assign b0.rd_en_i = rd;  assign b0.clear_i = clr;  assign b0.din_i = din;
   assign b1.wr_en_i = wr;  assign b1.rd_en_i = rd;  assign b1.clear_i = clr;  assign b1.din_i = din;
   assign b2.wr_en_i = wr;  assign b2.rd_en_i = rd;  assign b2.clear_i = clr;  assign b2.din_i = din;

   fifo_flagged #(.depth(8), .width(8), .afull_thresh(6), .aempty_thresh(2), .fwft(FIFO_MODE_REG))
      dut0 (.clk_i(clk), .reset_i(rst), .bus(b0));
   fifo_flagged #(.depth(8), .width(8), .afull_thresh(6), .aempty_thresh(2), .fwft(FIFO_MODE_FWFT))
      dut1 (.clk_i(clk), .reset_i(rst), .bus(b1));
   fifo_flagged #(.depth(5), .width(8), .afull_thresh(5), .aempty_thresh(1), .fwft(FIFO_MODE_FWFT))
      dut2 (.clk_i(clk), .reset_i(rst), .bus(b2));

   // Reference model: a queue per instance plus sticky flags and mode-0 output register.
   int         dep [3] = '{8, 8, 5};
   int         afv [3] = '{6, 6, 5};
   int         aev [3] = '{2, 2, 1};
   bit         fw  [3] = '{1'b0, 1'b1, 1'b1};
   logic [7:0] mq  [3][$];
   logic [7:0] mdout [3];
   bit         mov [3];
   bit         mun [3];

   typedef struct packed {
      logic [7:0] dout;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       ov;
      logic       un;
   } obs_t;

   function automatic obs_t get_obs(input int i);
      obs_t o;
      case (i)
         0: o = '{b0.dout_o, b0.count_o, b0.full_o, b0.empty_o, b0.almost_full_o,
                  b0.almost_empty_o, b0.overflow_o, b0.underflow_o};
         1: o = '{b1.dout_o, b1.count_o, b1.full_o, b1.empty_o, b1.almost_full_o,
                  b1.almost_empty_o, b1.overflow_o, b1.underflow_o};
         default: o = '{b2.dout_o, {1'b0, b2.count_o}, b2.full_o, b2.empty_o, b2.almost_full_o,
                        b2.almost_empty_o, b2.overflow_o, b2.underflow_o};
      endcase
      return o;
   endfunction

   task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", tag, inst, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         mdout[i] = 8'h00;
         mov[i]   = 1'b0;
         mun[i]   = 1'b0;
      end
   endtask

   task automatic model_step(input logic w, input logic r, input logic c, input logic [7:0] d);
      logic [7:0] head;
      bit rok, wok;
      for (int i = 0; i < 3; i++) begin
         if (c) begin
            mq[i].delete();
            mov[i] = 1'b0;
            mun[i] = 1'b0;
         end else begin
            rok = r && (mq[i].size() > 0);
            wok = w && ((mq[i].size() < dep[i]) || rok);
            if (r && !rok) mun[i] = 1'b1;
            if (w && !wok) mov[i] = 1'b1;
            if (rok) begin
               head = mq[i].pop_front();
               if (!fw[i]) mdout[i] = head;
            end
            if (wok) mq[i].push_back(d);
         end
      end
   endtask

   task automatic check_all(input bit at_reset);
      obs_t o;
      int   n;
      for (int i = 0; i < 3; i++) begin
         o = get_obs(i);
         n = mq[i].size();
         chk("count",     i, 32'(o.cnt),   32'(n));
         chk("empty",     i, 32'(o.empty), 32'(n == 0));
         chk("full",      i, 32'(o.full),  32'(n == dep[i]));
         chk("almost_fu", i, 32'(o.af),    32'(n >= afv[i]));
         chk("almost_em", i, 32'(o.ae),    32'(n <= aev[i]));
         chk("overflow",  i, 32'(o.ov),    32'(mov[i]));
         chk("underflow", i, 32'(o.un),    32'(mun[i]));
         if (at_reset)    chk("dout_rst", i, 32'(o.dout), 32'(0));
         else if (!fw[i]) chk("dout",     i, 32'(o.dout), 32'(mdout[i]));
         else if (n > 0)  chk("dout_ft",  i, 32'(o.dout), 32'(mq[i][0]));
      end
   endtask

   task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
      wr = w; rd = r; clr = c; din = d;
      @(posedge clk);
      model_step(w, r, c, d);
      #1;
      check_all(1'b0);
   endtask

   initial begin
      // Power-on reset
      model_reset();
      #3;
      check_all(1'b1);
      #5 rst = 1'b0;

      // Fill to full, then overfill
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'(k));
         if (k == 5) chk("af_after5", 0, 32'(b0.almost_full_o), 32'(0));
         if (k == 6) chk("af_after6", 0, 32'(b0.almost_full_o), 32'(1));
         if (k == 7) chk("full_after7", 0, 32'(b0.full_o), 32'(0));
         if (k == 8) chk("full_after8", 0, 32'(b0.full_o), 32'(1));
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h09);
      chk("ovf_9th", 0, 32'(b0.overflow_o), 32'(1));
      chk("cnt_9th", 0, 32'(b0.count_o), 32'(8));

      // Drain and underread
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         chk("drain_dout", 0, 32'(b0.dout_o), 32'(k));
         if (k == 5) chk("ae_cnt3", 0, 32'(b0.almost_empty_o), 32'(0));
         if (k == 6) chk("ae_cnt2", 0, 32'(b0.almost_empty_o), 32'(1));
         if (k == 8) chk("empty_end", 0, 32'(b0.empty_o), 32'(1));
      end
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("unf_9th", 0, 32'(b0.underflow_o), 32'(1));
      chk("dout_hold", 0, 32'(b0.dout_o), 32'(8'h08));

      // Flush with count 3 and a same-cycle write
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h31 + k));
      chk("cnt_pre_clr", 0, 32'(b0.count_o), 32'(3));
      cycle(1'b1, 1'b0, 1'b1, 8'h55);
      chk("cnt_clr", 0, 32'(b0.count_o), 32'(0));
      chk("unf_clr", 0, 32'(b0.underflow_o), 32'(0));
      chk("ovf_clr", 0, 32'(b0.overflow_o), 32'(0));
      chk("dout_clr", 0, 32'(b0.dout_o), 32'(8'h08));

      // FWFT: single write is visible without a read
      cycle(1'b1, 1'b0, 1'b0, 8'hA5);
      chk("fwft_dout", 1, 32'(b1.dout_o), 32'(8'hA5));
      chk("fwft_nempty", 1, 32'(b1.empty_o), 32'(0));
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fwft_hold", 1, 32'(b1.dout_o), 32'(8'hA5));
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("fwft_empty", 1, 32'(b1.empty_o), 32'(1));

      // Simultaneous read+write at empty
      cycle(1'b1, 1'b1, 1'b0, 8'h77);
      chk("rw_empty_unf", 0, 32'(b0.underflow_o), 32'(1));
      chk("rw_empty_cnt", 0, 32'(b0.count_o), 32'(1));

      // Simultaneous read+write at full
      for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + k));
      chk("full_pre_rw", 0, 32'(b0.full_o), 32'(1));
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 8'(8'hC0 + k));
         chk("rw_full_cnt", 0, 32'(b0.count_o), 32'(8));
      end

      // Asynchronous reset between clock edges
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_all(1'b1);
      chk("rst_async_cnt", 0, 32'(b0.count_o), 32'(0));
      #1 rst = 1'b0;

      // Pointer wrap with interleaved pairs, then sustained read+write at count 1
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'(k + 1));
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         chk("wrap_dout", 0, 32'(b0.dout_o), 32'(k + 1));
      end
      cycle(1'b1, 1'b0, 1'b0, 8'hE0);
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 8'(8'hE0 + k));
         chk("stream_ft", 1, 32'(b1.dout_o), 32'(8'(8'hE0 + k)));
      end
      chk("wrap_ovf", 2, 32'(b2.overflow_o), 32'(0));
      chk("wrap_unf", 2, 32'(b2.underflow_o), 32'(0));

      // Randomized traffic: write-heavy then read-heavy, occasional flush
      for (int n = 0; n < 600; n++) begin
         int wp;
         wp = (n < 300) ? 7 : 3;
         cycle(logic'($urandom_range(0, 9) < wp), logic'($urandom_range(0, 9) < 5),
               logic'($urandom_range(0, 59) == 0), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
